// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StMemWait  = 2'd1,
        StFlushing = 2'd2
    } ctrl_state_e;

    // Cycles FLUSH stays asserted after a redirect (entry cycle included)
    localparam int unsigned DefaultFlushCycles = 2;

    // Width of the flush down-counter; covers FLUSH_CYCLES up to 7
    localparam int unsigned FlushCntW = 3;

    // Canonical RISC-V NOP (addi x0, x0, 0) loaded by the bubble muxes
    localparam logic [31:0] NopInstr = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         INC,
    output logic [W-1:0] COUNT
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: add one unless already at all-ones
    always_comb begin
        count_d = count_q;
        if (INC && !(&count_q)) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared by reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage integer pipeline: turns cache
// readiness, scoreboard proceed, EX busy and branch redirects into stage
// enables, bubble controls, a flush pulse train and issue feedback.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = DefaultFlushCycles,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             INS_CACHE_READY,
    input  logic             DATA_CACHE_READY,
    input  logic             OPERANDS_READY,
    input  logic             EXSTAGE_BUSY,
    input  logic             BRANCH_TAKEN,
    output logic             PC_EN,
    output logic             IF_ID_EN,
    output logic             ID_EX_EN,
    output logic             EX_MEM_EN,
    output logic             MEM_WB_EN,
    output logic             ID_EX_BUBBLE,
    output logic             EX_MEM_BUBBLE,
    output logic             FLUSH,
    output logic             ISSUE,
    output logic [CNT_W-1:0] STALL_CYCLES
);

    localparam logic [FlushCntW-1:0] FlushCntInit = FlushCntW'(FLUSH_CYCLES - 1);

    ctrl_state_e          state_q, state_d;
    logic                 pending_flush_q, pending_flush_d;
    logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze;
    logic redirect;

    assign freeze   = !INS_CACHE_READY || !DATA_CACHE_READY;
    assign redirect = ((state_q == StRun) && BRANCH_TAKEN) ||
                      ((state_q == StMemWait) && (pending_flush_q || BRANCH_TAKEN));

    // Next-state and combinational stage controls
    always_comb begin
        state_d         = state_q;
        pending_flush_d = pending_flush_q;
        flush_cnt_d     = flush_cnt_q;
        PC_EN           = 1'b0;
        IF_ID_EN        = 1'b0;
        ID_EX_EN        = 1'b0;
        EX_MEM_EN       = 1'b0;
        MEM_WB_EN       = 1'b0;
        ID_EX_BUBBLE    = 1'b0;
        EX_MEM_BUBBLE   = 1'b0;
        FLUSH           = 1'b0;

        if (RST) begin
            // Everything held low; registers are cleared in the sequential block
        end else if (freeze) begin
            // Whole pipe holds; a flush in progress resumes where it stopped
            if (state_q != StFlushing) begin
                state_d = StMemWait;
                // Redirects are squashed while flushing, so only latch them otherwise
                if (BRANCH_TAKEN) begin
                    pending_flush_d = 1'b1;
                end
            end
        end else if (redirect) begin
            PC_EN           = 1'b1;
            IF_ID_EN        = 1'b1;
            ID_EX_EN        = 1'b1;
            ID_EX_BUBBLE    = 1'b1;
            EX_MEM_EN       = 1'b1;
            MEM_WB_EN       = 1'b1;
            FLUSH           = 1'b1;
            pending_flush_d = 1'b0;
            flush_cnt_d     = FlushCntInit;
            // A single-cycle flush is complete after the entry cycle
            state_d         = (FLUSH_CYCLES > 1) ? StFlushing : StRun;
        end else if (state_q == StFlushing) begin
            IF_ID_EN     = 1'b1;
            ID_EX_EN     = 1'b1;
            ID_EX_BUBBLE = 1'b1;
            EX_MEM_EN    = 1'b1;
            MEM_WB_EN    = 1'b1;
            FLUSH        = 1'b1;
            flush_cnt_d  = flush_cnt_q - FlushCntW'(1);
            if (flush_cnt_q <= FlushCntW'(1)) begin
                state_d = StRun;
            end
        end else begin
            // RUN, or leaving MEM_WAIT with nothing pending: normal rules apply now
            state_d   = StRun;
            MEM_WB_EN = 1'b1;
            EX_MEM_EN = 1'b1;
            if (EXSTAGE_BUSY) begin
                EX_MEM_BUBBLE = 1'b1;
            end else if (!OPERANDS_READY) begin
                ID_EX_EN     = 1'b1;
                ID_EX_BUBBLE = 1'b1;
            end else begin
                PC_EN    = 1'b1;
                IF_ID_EN = 1'b1;
                ID_EX_EN = 1'b1;
            end
        end
    end

    assign ISSUE = ID_EX_EN & ~ID_EX_BUBBLE & ~FLUSH & ~RST;

    // Sequencer state registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= StRun;
            pending_flush_q <= 1'b0;
            flush_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            pending_flush_q <= pending_flush_d;
            flush_cnt_q     <= flush_cnt_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .INC   (~ISSUE),
        .COUNT (STALL_CYCLES)
    );

endmodule
